// File: rtl/gameport_axis_timer.sv
// Gameport one-shot axis timers: a port write loads each axis with a count derived from an
// analog stick value or digital direction flags, then the count runs down once every DIV clocks.
module gameport_axis_timer #(
   parameter int NUM_AXES  = 4,
   parameter int COUNT_W   = 9,
   parameter int DIV       = 266,
   parameter int CENTER    = 200,
   parameter int MIN_COUNT = 8,
   parameter int MAX_COUNT = 391,
   parameter int RETRIGGER = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_AXES*8-1:0]         ana,
   input  logic [NUM_AXES-1:0]           dig_neg,
   input  logic [NUM_AXES-1:0]           dig_pos,
   input  logic [3:0]                    buttons,
   input  logic                          write,
   output logic [7:0]                    readdata,
   output logic [NUM_AXES-1:0]           axis_active,
   output logic [NUM_AXES*COUNT_W-1:0]   axis_count
);

   localparam int PRE_W = $clog2(DIV);
   localparam int SUM_W = COUNT_W + 2;
   localparam logic [PRE_W-1:0]        PRE_LAST = PRE_W'(DIV - 1);
   localparam logic signed [SUM_W-1:0] S_MIN    = SUM_W'(MIN_COUNT);
   localparam logic signed [SUM_W-1:0] S_MAX    = SUM_W'(MAX_COUNT);
   localparam logic signed [SUM_W-1:0] S_CENTER = SUM_W'(CENTER);

   function automatic logic [COUNT_W-1:0] sat_count(input logic signed [SUM_W-1:0] v);
      if (v < S_MIN)
         return COUNT_W'(MIN_COUNT);
      else if (v > S_MAX)
         return COUNT_W'(MAX_COUNT);
      else
         return v[COUNT_W-1:0];
   endfunction

   // Analog scaling is 1.5x the stick value around CENTER; any nonzero analog value overrides the flags.
   function automatic logic [COUNT_W-1:0] load_value(input logic signed [7:0] a,
                                                     input logic neg,
                                                     input logic pos);
      logic signed [SUM_W-1:0] ext;
      logic signed [SUM_W-1:0] sum;
      ext = SUM_W'(a);
      sum = S_CENTER + ext + (ext >>> 1);
      if (a != '0)
         return sat_count(sum);
      else if (neg)
         return COUNT_W'(MIN_COUNT);
      else if (pos)
         return COUNT_W'(MAX_COUNT);
      else
         return COUNT_W'(CENTER);
   endfunction

   logic [PRE_W-1:0] r_presc;
   logic             w_tick;
   logic             w_any_active;
   logic             w_presc_clr;

   assign w_tick       = (r_presc == PRE_LAST);
   assign w_any_active = |axis_active;
   // Without retrigger, a write must not restart the prescaler under a running pulse.
   assign w_presc_clr  = write && ((RETRIGGER != 0) || !w_any_active);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_presc <= '0;
      else if (w_presc_clr || w_tick)
         r_presc <= '0;
      else
         r_presc <= r_presc + 1'b1;
   end

   for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
      logic [COUNT_W-1:0] r_count;
      logic [COUNT_W-1:0] w_load_val;
      logic               w_load_en;

      assign w_load_val = load_value($signed(ana[8*g +: 8]), dig_neg[g], dig_pos[g]);
      assign w_load_en  = write && ((RETRIGGER != 0) || (r_count == '0));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            r_count <= '0;
         else if (w_load_en)
            r_count <= w_load_val;
         else if (w_tick && (r_count != '0))
            r_count <= r_count - 1'b1;
      end

      assign axis_active[g]                     = (r_count != '0);
      assign axis_count[g*COUNT_W +: COUNT_W]   = r_count;
   end

   // Readdata: buttons pass a capture stage (p0), then everything lands in the port register (p1).
   logic [3:0] r_btn_n_p0;
   logic [3:0] w_axis_bits;
   logic [7:0] r_readdata_p1;

   always_comb begin
      w_axis_bits = 4'hF;
      for (int i = 0; i < NUM_AXES; i++)
         w_axis_bits[i] = axis_active[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_btn_n_p0    <= 4'hF;
         r_readdata_p1 <= 8'h00;
      end else begin
         r_btn_n_p0    <= ~buttons;
         r_readdata_p1 <= {r_btn_n_p0, w_axis_bits};
      end
   end

   assign readdata = r_readdata_p1;

endmodule

// File: tb/tb_gameport_axis_timer.sv
// Bench for gameport_axis_timer: five differently parameterised instances share one stimulus bus
// and are checked against an arithmetic load/tick model through a cycle-stamped scoreboard queue.
module tb_gameport_axis_timer;

   localparam int NI = 5;
   localparam int P_NA  [NI] = '{4, 4, 4, 4, 2};
   localparam int P_DIV [NI] = '{266, 266, 4, 4, 3};
   localparam int P_CEN [NI] = '{200, 300, 5, 5, 1000};
   localparam int P_MIN [NI] = '{8, 8, 2, 2, 100};
   localparam int P_MAX [NI] = '{391, 391, 300, 300, 4000};
   localparam int P_RT  [NI] = '{1, 1, 1, 0, 1};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        write;
   logic [31:0] ana;
   logic [3:0]  dig_neg, dig_pos, buttons;

   logic [7:0]  rd0, rd1, rd2, rd3, rd4;
   logic [3:0]  act0, act1, act2, act3;
   logic [1:0]  act4;
   logic [35:0] cnt0, cnt1, cnt2, cnt3;
   logic [23:0] cnt4;

   always #5 clk = ~clk;

   gameport_axis_timer #(.NUM_AXES(4), .COUNT_W(9), .DIV(266), .CENTER(200), .MIN_COUNT(8),
                         .MAX_COUNT(391), .RETRIGGER(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .ana(ana), .dig_neg(dig_neg), .dig_pos(dig_pos),
      .buttons(buttons), .write(write), .readdata(rd0), .axis_active(act0), .axis_count(cnt0));
   gameport_axis_timer #(.NUM_AXES(4), .COUNT_W(9), .DIV(266), .CENTER(300), .MIN_COUNT(8),
                         .MAX_COUNT(391), .RETRIGGER(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ana(ana), .dig_neg(dig_neg), .dig_pos(dig_pos),
      .buttons(buttons), .write(write), .readdata(rd1), .axis_active(act1), .axis_count(cnt1));
   gameport_axis_timer #(.NUM_AXES(4), .COUNT_W(9), .DIV(4), .CENTER(5), .MIN_COUNT(2),
                         .MAX_COUNT(300), .RETRIGGER(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .ana(ana), .dig_neg(dig_neg), .dig_pos(dig_pos),
      .buttons(buttons), .write(write), .readdata(rd2), .axis_active(act2), .axis_count(cnt2));
   gameport_axis_timer #(.NUM_AXES(4), .COUNT_W(9), .DIV(4), .CENTER(5), .MIN_COUNT(2),
                         .MAX_COUNT(300), .RETRIGGER(0)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .ana(ana), .dig_neg(dig_neg), .dig_pos(dig_pos),
      .buttons(buttons), .write(write), .readdata(rd3), .axis_active(act3), .axis_count(cnt3));
   gameport_axis_timer #(.NUM_AXES(2), .COUNT_W(12), .DIV(3), .CENTER(1000), .MIN_COUNT(100),
                         .MAX_COUNT(4000), .RETRIGGER(1)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .ana(ana[15:0]), .dig_neg(dig_neg[1:0]), .dig_pos(dig_pos[1:0]),
      .buttons(buttons), .write(write), .readdata(rd4), .axis_active(act4), .axis_count(cnt4));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int kind;
      int inst;
      int ax;
      int exp;
   } chk_t;
   chk_t q[$];
   int n_checks = 0;
   int n_fail   = 0;

   function automatic int dut_count(int inst, int ax);
      case (inst)
         0: return int'(cnt0[ax*9 +: 9]);
         1: return int'(cnt1[ax*9 +: 9]);
         2: return int'(cnt2[ax*9 +: 9]);
         3: return int'(cnt3[ax*9 +: 9]);
         default: return int'(cnt4[ax*12 +: 12]);
      endcase
   endfunction

   function automatic int dut_act(int inst, int ax);
      case (inst)
         0: return int'(act0[ax]);
         1: return int'(act1[ax]);
         2: return int'(act2[ax]);
         3: return int'(act3[ax]);
         default: return int'(act4[ax]);
      endcase
   endfunction

   function automatic int dut_rd(int inst);
      case (inst)
         0: return int'(rd0);
         1: return int'(rd1);
         2: return int'(rd2);
         3: return int'(rd3);
         default: return int'(rd4);
      endcase
   endfunction

   // Model: each axis remembers the cycle it was loaded and the loaded value; the prescaler is
   // described by the cycle m_E at which it last read 0, so ticks fall where (k-m_E)%DIV == DIV-1.
   int m_E [NI];
   int m_w [NI][4];
   int m_c [NI][4];
   bit m_rst = 1'b1;

   function automatic int ticks(int inst, int a, int b);
      int fa, fb;
      if (b < a) return 0;
      fb = (b - m_E[inst] + 1 >= 0) ? (b - m_E[inst] + 1) / P_DIV[inst] : 0;
      fa = (a - m_E[inst] >= 0) ? (a - m_E[inst]) / P_DIV[inst] : 0;
      return fb - fa;
   endfunction

   function automatic int mcount(int inst, int ax, int n);
      int t;
      if (m_c[inst][ax] == 0) return 0;
      t = ticks(inst, m_w[inst][ax] + 1, n - 1);
      return (m_c[inst][ax] > t) ? m_c[inst][ax] - t : 0;
   endfunction

   function automatic int exp_load(int inst, int a, bit neg, bit pos);
      int v;
      if (a != 0) begin
         v = P_CEN[inst] + a + ((a >= 0) ? a / 2 : -((1 - a) / 2));
         if (v < P_MIN[inst]) v = P_MIN[inst];
         if (v > P_MAX[inst]) v = P_MAX[inst];
         return v;
      end
      if (neg) return P_MIN[inst];
      if (pos) return P_MAX[inst];
      return P_CEN[inst];
   endfunction

   task automatic model_write(int w);
      bit elig [4];
      bit any;
      logic signed [7:0] sb;
      if (m_rst) return;
      for (int i = 0; i < NI; i++) begin
         any = 1'b0;
         for (int a = 0; a < P_NA[i]; a++) begin
            elig[a] = (P_RT[i] != 0) || (mcount(i, a, w) == 0);
            if (mcount(i, a, w) != 0) any = 1'b1;
         end
         for (int a = 0; a < P_NA[i]; a++) begin
            if (elig[a]) begin
               sb = ana[8*a +: 8];
               m_w[i][a] = w;
               m_c[i][a] = exp_load(i, int'(sb), dig_neg[a], dig_pos[a]);
            end
         end
         if ((P_RT[i] != 0) || !any) m_E[i] = w + 1;
      end
   endtask

   // rd_mode: 0 none, 1 normal, 2 first cycle after reset release, 3 held in reset.
   task automatic push_cycle(int n, int rd_mode);
      int c;
      logic [7:0] e;
      for (int i = 0; i < NI; i++) begin
         for (int a = 0; a < P_NA[i]; a++) begin
            c = mcount(i, a, n);
            q.push_back('{n, 0, i, a, c});
            q.push_back('{n, 1, i, a, (c != 0) ? 1 : 0});
         end
         if (rd_mode != 0) begin
            e[7:4] = (rd_mode == 1) ? ~buttons : ((rd_mode == 2) ? 4'hF : 4'h0);
            for (int b = 0; b < 4; b++) begin
               if (rd_mode == 3)      e[b] = 1'b0;
               else if (b < P_NA[i])  e[b] = (mcount(i, b, n - 1) != 0);
               else                   e[b] = 1'b1;
            end
            q.push_back('{n, 2, i, 0, int'(e)});
         end
      end
   endtask

   task automatic push_window(int w, int horizon);
      int cl[$];
      int b, prev;
      for (int k = 1; k <= 10; k++)
         if (k < horizon) cl.push_back(w + k);
      if (horizon > 12)
         repeat (3) cl.push_back(w + int'($urandom_range(horizon - 1, 11)));
      // Expected pulse end from the pulse-width rule: zero exactly C*DIV cycles after the load shows.
      for (int i = 0; i < NI; i++)
         for (int a = 0; a < P_NA[i]; a++)
            if (m_w[i][a] == w && m_c[i][a] > 0) begin
               b = w + 1 + m_c[i][a] * P_DIV[i];
               for (int d = -1; d <= 2; d++)
                  if (b + d < w + horizon) cl.push_back(b + d);
            end
      cl.sort();
      prev = -1;
      foreach (cl[k]) begin
         if (cl[k] != prev) push_cycle(cl[k], (cl[k] >= w + 2) ? 1 : 0);
         prev = cl[k];
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_until(int n);
      while (cyc < n) step();
   endtask

   task automatic prep(logic [31:0] a, logic [3:0] neg, logic [3:0] pos, logic [3:0] btn);
      ana = a; dig_neg = neg; dig_pos = pos; buttons = btn;
      step();
      step();
   endtask

   task automatic do_write(int horizon);
      int w;
      w = cyc;
      model_write(w);
      if (!m_rst) push_window(w, horizon);
      write = 1'b1;
      step();
      write = 1'b0;
      wait_until(w + horizon);
   endtask

   task automatic enter_reset();
      m_rst = 1'b1;
      for (int i = 0; i < NI; i++)
         for (int a = 0; a < 4; a++) m_c[i][a] = 0;
      push_cycle(cyc, 3);
      rst_n = 1'b0;
   endtask

   task automatic leave_reset();
      int r;
      rst_n = 1'b1;
      r = cyc;
      m_rst = 1'b0;
      for (int i = 0; i < NI; i++) m_E[i] = r;
      push_cycle(r + 1, 2);
      push_cycle(r + 2, 1);
      push_cycle(r + 3, 1);
      wait_until(r + 4);
   endtask

   always @(negedge clk) begin
      chk_t c;
      int got;
      string nm;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         c = q.pop_front();
         n_checks++;
         nm = (c.kind == 0) ? "count" : ((c.kind == 1) ? "active" : "readdata");
         if (c.cyc < cyc) begin
            n_fail++;
            $display("FAIL %s inst%0d ax%0d: check for cycle %0d not reached in time (now %0d)",
                     nm, c.inst, c.ax, c.cyc, cyc);
         end else begin
            got = (c.kind == 0) ? dut_count(c.inst, c.ax) :
                  ((c.kind == 1) ? dut_act(c.inst, c.ax) : dut_rd(c.inst));
            if (got != c.exp) begin
               n_fail++;
               $display("FAIL %s inst%0d ax%0d cycle %0d: got 0x%0h expected 0x%0h",
                        nm, c.inst, c.ax, cyc, got, c.exp);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] ra;
      rst_n = 1'b0; write = 1'b0; ana = '0; dig_neg = '0; dig_pos = '0; buttons = 4'b0101;
      for (int i = 0; i < NI; i++) begin
         m_E[i] = 0;
         for (int a = 0; a < 4; a++) begin m_w[i][a] = 0; m_c[i][a] = 0; end
      end

      // Reset hold, a write that must be ignored, then release with buttons = 0101.
      step(); step(); step();
      push_cycle(cyc, 3);
      write = 1'b1;
      step();
      write = 1'b0;
      push_cycle(cyc, 3);
      leave_reset();

      // Digital stick: axis0 full negative, axis1 full positive.
      prep(32'h0, 4'b0001, 4'b0010, 4'b0000);
      do_write(2140);

      // Analog extremes on axis0.
      prep(32'h0000_007F, 4'b0000, 4'b0000, 4'b0000);
      do_write(30);
      prep(32'h0000_0080, 4'b0000, 4'b0000, 4'b0011);
      do_write(30);

      // Long pulses, then a second write about 100 ticks later (DIV=4 instances).
      prep(32'h0, 4'b0000, 4'b1111, 4'b1000);
      do_write(400);
      prep(32'h1020_F080, 4'b0000, 4'b0000, 4'b1000);
      do_write(40);

      // Write landing on a prescaler tick of instance 2.
      prep(32'h0, 4'b0000, 4'b0000, 4'b0110);
      while (((cyc - m_E[2]) % P_DIV[2]) != P_DIV[2] - 1) step();
      do_write(14);

      // Randomised loads.
      repeat (15) begin
         for (int a = 0; a < 4; a++)
            ra[8*a +: 8] = ($urandom_range(1, 0) == 0) ? 8'h00 : 8'($urandom);
         prep(ra, 4'($urandom), 4'($urandom), 4'($urandom));
         do_write(int'($urandom_range(60, 5)));
      end

      // Reset asserted mid-pulse, then recovery.
      prep(32'h0, 4'b0000, 4'b1111, 4'b1001);
      do_write(25);
      enter_reset();
      step();
      push_cycle(cyc, 3);
      step();
      leave_reset();
      prep(32'h0000_4000, 4'b0001, 4'b0000, 4'b0000);
      do_write(20);

      step();
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard drain: %0d entries left, required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
